btn_debounce: RTL

- Multi-channel push-button/switch conditioner for the 2048 board I/O.
- Consumes one bit of the free-running `clkdiv` bus as its sample-rate source.
- Synchronizes, debounces and edge-detects raw buttons/switches.
- Feeds clean levels to the clock-control switches and one-cycle move pulses to the game FSM.

---
 rtl/btn_debounce.sv | 118 +++++++++++
 1 files changed

// File: rtl/btn_debounce.sv
// Multi-channel button conditioner: 2-flop sync, tick-paced debounce, press/release pulses.
// Define BTN_DEBOUNCE_REPEAT_EN to add auto-repeat press pulses while a button is held.
module btn_debounce #(
    parameter int unsigned N            = 5,
    parameter int unsigned STABLE_CNT   = 4,
    parameter int unsigned REPEAT_DELAY = 32,
    parameter int unsigned REPEAT_RATE  = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_src,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    if (STABLE_CNT < 1 || STABLE_CNT > 15 || REPEAT_RATE < 1 ||
        REPEAT_RATE > REPEAT_DELAY || REPEAT_DELAY > 255) begin : g_param_check
        $error("btn_debounce: illegal STABLE_CNT/REPEAT_DELAY/REPEAT_RATE");
    end

    logic [N-1:0]     sync1;
    logic [N-1:0]     btn_s;
    logic             src_d;
    logic             tick_c;
    logic [CNT_W-1:0] cnt      [N];
    logic [CNT_W-1:0] cnt_next [N];
    logic [N-1:0]     level_next;
    logic [N-1:0]     press_next;
    logic [N-1:0]     release_next;

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int unsigned HOLD_W = 8;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_RATE);

    logic [HOLD_W-1:0] hold      [N];
    logic [HOLD_W-1:0] hold_next [N];
`endif

    assign tick_c = sample_src & ~src_d;

    // Next-state: debounce counters, levels and edge pulses
    always_comb begin
        level_next   = btn_level;
        press_next   = '0;
        release_next = '0;
        for (int i = 0; i < N; i++) begin
            cnt_next[i] = cnt[i];
            if (tick_c) begin
                if (btn_s[i] != btn_level[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        level_next[i] = ~btn_level[i];
                        cnt_next[i]   = '0;
                    end else begin
                        cnt_next[i] = cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt_next[i] = '0;
                end
            end
        end
        press_next   = level_next & ~btn_level;
        release_next = btn_level & ~level_next;
`ifdef BTN_DEBOUNCE_REPEAT_EN
        // A release tick clears hold and suppresses any repeat in that clk
        for (int i = 0; i < N; i++) begin
            hold_next[i] = hold[i];
            if (!btn_level[i] || !level_next[i]) begin
                hold_next[i] = '0;
            end else if (tick_c) begin
                if (hold[i] == HOLD_LAST) begin
                    press_next[i] = 1'b1;
                    hold_next[i]  = HOLD_RELOAD;
                end else begin
                    hold_next[i] = hold[i] + HOLD_W'(1);
                end
            end
        end
`endif
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1       <= '0;
            btn_s       <= '0;
            src_d       <= 1'b0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
`ifdef BTN_DEBOUNCE_REPEAT_EN
                hold[i] <= '0;
`endif
            end
        end else begin
            sync1       <= btn_in;
            btn_s       <= sync1;
            src_d       <= sample_src;
            btn_level   <= level_next;
            btn_press   <= press_next;
            btn_release <= release_next;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= cnt_next[i];
`ifdef BTN_DEBOUNCE_REPEAT_EN
                hold[i] <= hold_next[i];
`endif
            end
        end
    end

endmodule
